uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// uart_tx -- AXI-Stream to asynchronous serial transmitter.
//
// Sends one frame per accepted word: a start bit (0), DATA_WIDTH data bits
// LSB first, then a stop bit (1). There is no parity. Each bit is held for
// P*8 clock cycles. P is the prescale value captured at the handshake, and a
// captured value of 0 is treated as 1.
//
// Ports
//   clk            in   single clock; all logic runs on its rising edge
//   rst            in   synchronous, active-high reset
//   s_axis_tdata   in   [DATA_WIDTH] word to transmit
//   s_axis_tvalid  in   s_axis_tdata is valid
//   s_axis_tready  out  the block accepts a word on this cycle's edge
//   txd            out  serial line, idles high
//   busy           out  a frame is in progress
//   prescale       in   [16] bit period = prescale*8 clk cycles
//
// All outputs are registered. s_axis_tvalid only feeds the state register,
// so s_axis_tready never depends combinationally on it.
//------------------------------------------------------------------------------
`timescale 1ns / 1ps

module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale
);

  // 19 bits holds 0xFFFF*8 without overflow.
  localparam int CNT_W = 19;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_period;   // bit period captured at handshake
  logic [CNT_W-1:0]      r_cnt;      // cycles left in the current bit, minus one
  logic [DATA_WIDTH-1:0] r_shift;    // remaining data bits, next bit in [0]
  logic [BIT_W-1:0]      r_bit_idx;  // index of the data bit on the line
  logic                  r_txd;
  logic                  r_busy;
  logic                  r_tready;

  logic [CNT_W-1:0]      w_in_period;
  logic                  w_handshake;
  logic                  w_bit_done;

  // A prescale of 0 runs at the fastest legal rate (P = 1).
  assign w_in_period = (prescale == 16'd0) ? CNT_W'(8) : {prescale, 3'b000};
  assign w_handshake = s_axis_tvalid & r_tready;
  assign w_bit_done  = (r_cnt == '0);

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments, so every branch below reads
    // the values from before this edge, whatever order the statements are in.
    if (rst) begin
      // NOTE: this reset is synchronous. It is sampled only on the clock edge,
      // so it must stay inside this block and out of the sensitivity list.
      r_state   <= IDLE;
      r_period  <= '0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_tready  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // The first edge after reset raises tready. A handshake needs the
          // registered tready, so no word is taken on that edge.
          r_txd    <= 1'b1;
          r_busy   <= 1'b0;
          r_tready <= 1'b1;
          if (w_handshake) begin
            r_state   <= START;
            r_shift   <= s_axis_tdata;
            r_period  <= w_in_period;
            r_cnt     <= w_in_period - 1'b1;
            r_bit_idx <= '0;
            r_txd     <= 1'b0;
            r_busy    <= 1'b1;
            r_tready  <= 1'b0;
          end
        end

        START: begin
          if (w_bit_done) begin
            r_state   <= DATA;
            r_txd     <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_cnt     <= r_period - 1'b1;
            r_bit_idx <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        DATA: begin
          if (w_bit_done) begin
            r_cnt <= r_period - 1'b1;
            if (r_bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
              r_state <= STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        STOP: begin
          // Going back to IDLE raises tready. With tvalid held, the next
          // start bit then goes out on the following edge.
          if (w_bit_done) begin
            r_state  <= IDLE;
            r_tready <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready = r_tready;
  assign txd           = r_txd;
  assign busy          = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
//------------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx (DATA_WIDTH = 8).
//
// The reference model is a bit list for each frame: {stop, data, start}. The
// bench expects bit k/(P*8) on the line at cycle k after the handshake. It
// also decodes each frame by sampling txd in the middle of every bit, the way
// a receiver would. Between frames, and while a frame is running, tvalid,
// tdata and prescale are filled with random values so the bench can see that
// the DUT ignores them.
//------------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_uart_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          txd;
  logic          busy;
  logic [15:0]   prescale;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .txd           (txd),
    .busy          (busy),
    .prescale      (prescale)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Sends one frame and checks it against the model, one sample per cycle.
  //   drive      present data/presc with tvalid before the handshake
  //   keep       hold tvalid during the frame (back-to-back); if chg_at >= 0,
  //              switch tdata/prescale at that cycle
  //   expect_now the handshake must happen on the very next edge
  task automatic run_frame(input string tag, input logic [DW-1:0] data,
                           input logic [15:0] presc, input bit drive, input bit keep,
                           input int chg_at, input logic [DW-1:0] chg_data,
                           input logic [15:0] chg_presc, input bit expect_now);
    int            p8, n, waited, txd_err, busy_err, low_len;
    bit            low_run;
    logic [DW+1:0] frame_bits;
    logic [DW+1:0] mid;
    logic          exp_bit;

    p8         = (presc == 16'd0) ? 8 : 8 * int'(presc);
    n          = (DW + 2) * p8;
    frame_bits = {1'b1, data, 1'b0};

    @(negedge clk);
    if (drive) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = data;
      prescale      = presc;
    end
    waited = 0;
    while (s_axis_tready !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (expect_now) check({tag, " gap"}, waited, 0);
    else            check({tag, " accept"}, 32'(waited < 1000), 1);

    @(posedge clk);  // handshake edge
    #1;
    txd_err  = 0;
    busy_err = 0;
    low_len  = 0;
    low_run  = 1'b1;
    mid      = '0;
    for (int k = 0; k <= n; k++) begin
      if (low_run && s_axis_tready === 1'b0) low_len++;
      else low_run = 1'b0;
      if (k < n) begin
        exp_bit = frame_bits[k / p8];
        if (txd !== exp_bit) txd_err++;
        if (busy !== 1'b1) busy_err++;
        if (k % p8 == p8 / 2) mid[k / p8] = txd;
        @(negedge clk);
        if (keep) begin
          if (k == chg_at) begin
            s_axis_tdata = chg_data;
            prescale     = chg_presc;
          end
        end else if (k < n - 1) begin
          s_axis_tvalid = 1'($urandom);
          s_axis_tdata  = DW'($urandom);
          prescale      = 16'($urandom);
        end else begin
          s_axis_tvalid = 1'b0;
        end
        @(posedge clk);
        #1;
      end
    end

    check({tag, " txd waveform errors"}, txd_err, 0);
    check({tag, " busy errors"}, busy_err, 0);
    check({tag, " tready low cycles"}, low_len, n);
    check({tag, " decoded data"}, mid[DW:1], data);
    check({tag, " start/stop levels"}, {mid[DW+1], mid[0]}, 2'b10);
    check({tag, " end state txd/busy/tready"}, {txd, busy, s_axis_tready}, 3'b101);
  endtask

  logic [DW-1:0] rd;
  logic [DW-1:0] rm_data;
  int            waited;

  initial begin
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    prescale      = 16'd6;

    // Reset is held for 5 cycles, then released.
    repeat (5) begin
      @(posedge clk);
      #1;
      check("reset hold txd/busy/tready", {txd, busy, s_axis_tready}, 3'b100);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset release txd/busy/tready", {txd, busy, s_axis_tready}, 3'b101);

    // A single frame at prescale 6 (48 cycles per bit).
    run_frame("single A5", 8'hA5, 16'd6, 1'b1, 1'b0, -1, '0, '0, 1'b0);

    // Back-to-back frames with tvalid held; the second word is loaded mid-frame.
    run_frame("b2b A5", 8'hA5, 16'd6, 1'b1, 1'b1, 10, 8'h5A, 16'd6, 1'b0);
    run_frame("b2b 5A", 8'h5A, 16'd6, 1'b0, 1'b0, -1, '0, '0, 1'b1);

    // prescale changes 6->3 and tdata changes while frame 1 is on the line.
    run_frame("chg f1", 8'h3C, 16'd6, 1'b1, 1'b1, 150, 8'hC3, 16'd3, 1'b0);
    run_frame("chg f2", 8'hC3, 16'd3, 1'b0, 1'b0, -1, '0, '0, 1'b1);

    // prescale 0 gives 8 cycles per bit and an 80-cycle frame.
    run_frame("presc0 FF", 8'hFF, 16'd0, 1'b1, 1'b0, -1, '0, '0, 1'b0);

    // Reset during data bit 3.
    rm_data = 8'h96;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rm_data;
    prescale      = 16'd6;
    waited = 0;
    while (s_axis_tready !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);  // handshake edge
    #1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    repeat (200) @(negedge clk);  // 200 cycles in: bit slot 4 = data bit 3
    check("rst mid: data bit 3 on line", txd, rm_data[3]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst mid: txd/busy/tready after edge", {txd, busy, s_axis_tready}, 3'b100);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst mid: release txd/busy/tready", {txd, busy, s_axis_tready}, 3'b101);
    rd = DW'($urandom);
    run_frame("after rst", rd, 16'd6, 1'b1, 1'b0, -1, '0, '0, 1'b0);

    // Random words at random small prescales.
    for (int i = 0; i < 4; i++) begin
      rd = DW'($urandom);
      run_frame("random", rd, 16'($urandom_range(0, 4)), 1'b1, 1'b0, -1, '0, '0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
